// File: rtl/mem_arbiter_if.sv
// Shared memory-port bus between two masters, the arbiter and the memory block.
// The arbiter uses the slave view; the masters/memory side use the master view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req0, req1;
    logic                  write0, write1;
    logic                  lock0, lock1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  ack0, ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  busy;

    modport slave (
        input  req0, req1, write0, write1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, mem_data_out,
        output gnt0, gnt1, ack0, ack1, rdata,
        output mem_address, mem_data_in, mem_write, busy
    );

    modport master (
        output req0, req1, write0, write1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, mem_data_out,
        input  gnt0, gnt1, ack0, ack1, rdata,
        input  mem_address, mem_data_in, mem_write, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-master arbiter for the shared 8-bit memory/IO port, with a
// bounded lock so one master can run atomic read-modify-write sequences.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] LIMIT = 4'(LOCK_LIMIT);

    state_t     state;
    logic       cur;
    logic       last_gnt;
    logic       lock_valid;
    logic       lock_owner;
    logic [3:0] lock_cnt;
    logic       write_q;

    logic       pick_valid;
    logic       pick;
    logic       lock_clear;
    logic       owner_req;
    logic       other_req;
    logic       cur_lock;

    assign owner_req = lock_owner ? bus.req1 : bus.req0;
    assign other_req = lock_owner ? bus.req0 : bus.req1;
    assign cur_lock  = cur ? bus.lock1 : bus.lock0;

    always_comb begin
        pick_valid = bus.req0 | bus.req1;
        pick       = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
        lock_clear = 1'b0;
        if (lock_valid) begin
            if (owner_req && other_req && lock_cnt == LIMIT) begin
                // Lock budget spent: hand one transaction to the waiting master.
                pick       = ~lock_owner;
                lock_clear = 1'b1;
            end else if (owner_req) begin
                pick = lock_owner;
            end else begin
                lock_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cur         <= 1'b0;
            last_gnt    <= 1'b1;
            lock_valid  <= 1'b0;
            lock_owner  <= 1'b0;
            lock_cnt    <= 4'd0;
            write_q     <= 1'b0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.ack0    <= 1'b0;
            bus.ack1    <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_clear) begin
                        lock_valid <= 1'b0;
                        lock_cnt   <= 4'd0;
                    end
                    if (pick_valid) begin
                        state           <= ACCESS;
                        cur             <= pick;
                        last_gnt        <= pick;
                        bus.gnt0        <= ~pick;
                        bus.gnt1        <= pick;
                        bus.mem_address <= pick ? bus.addr1  : bus.addr0;
                        bus.mem_data_in <= pick ? bus.wdata1 : bus.wdata0;
                        write_q         <= pick ? bus.write1 : bus.write0;
                    end
                end
                ACCESS: begin
                    state    <= ACK;
                    write_q  <= 1'b0;
                    bus.ack0 <= ~cur;
                    bus.ack1 <= cur;
                end
                ACK: begin
                    state    <= IDLE;
                    bus.gnt0 <= 1'b0;
                    bus.gnt1 <= 1'b0;
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    if (cur_lock) begin
                        lock_valid <= 1'b1;
                        lock_owner <= cur;
                        // Saturate so the equality test against LIMIT cannot be skipped.
                        if (lock_cnt < LIMIT) lock_cnt <= lock_cnt + 4'd1;
                    end else begin
                        lock_valid <= 1'b0;
                        lock_cnt   <= 4'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with reset kills a write whose ACCESS cycle coincides with reset,
    // since the memory samples mem_write on that same edge.
    assign bus.mem_write = write_q & reset;
    assign bus.rdata     = (state == ACK) ? bus.mem_data_out : '0;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model behind it.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LOCK_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [256] = '{default: 8'h00};

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_in;
        bus.mem_data_out <= mem[bus.mem_address];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_gnt0"}, bus.gnt0, 1'b0);
        chk1({tag, "_gnt1"}, bus.gnt1, 1'b0);
        chk1({tag, "_ack0"}, bus.ack0, 1'b0);
        chk1({tag, "_ack1"}, bus.ack1, 1'b0);
        chk1({tag, "_mwr"},  bus.mem_write, 1'b0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk8({tag, "_addr"}, bus.mem_address, 8'h00);
        chk8({tag, "_din"},  bus.mem_data_in, 8'h00);
        chk8({tag, "_rdata"}, bus.rdata, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
    endtask

    logic exp_g [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.write0 = 1'b0; bus.write1 = 1'b0;
        bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        bus.addr0 = 8'h00; bus.addr1 = 8'h00;
        bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;

        // Reset state
        step(); step(); step();
        chk_all_zero("rst");

        // Single CPU write then read of 0x10
        reset = 1'b1;
        bus.req0 = 1'b1; bus.write0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5;
        step();
        chk1("wr_gnt0", bus.gnt0, 1'b1);
        chk1("wr_gnt1", bus.gnt1, 1'b0);
        chk1("wr_mwr_access", bus.mem_write, 1'b1);
        chk8("wr_addr", bus.mem_address, 8'h10);
        chk8("wr_din", bus.mem_data_in, 8'hA5);
        chk1("wr_busy", bus.busy, 1'b1);
        chk1("wr_ack_early", bus.ack0, 1'b0);
        step();
        chk1("wr_ack0", bus.ack0, 1'b1);
        chk1("wr_mwr_ack", bus.mem_write, 1'b0);
        chk1("wr_gnt_ack", bus.gnt0, 1'b1);
        step();
        chk1("wr_idle_gnt", bus.gnt0, 1'b0);
        chk1("wr_idle_ack", bus.ack0, 1'b0);
        chk1("wr_idle_busy", bus.busy, 1'b0);
        bus.write0 = 1'b0;
        step();
        chk1("rd_gnt0", bus.gnt0, 1'b1);
        chk1("rd_mwr", bus.mem_write, 1'b0);
        chk8("rd_addr", bus.mem_address, 8'h10);
        step();
        chk1("rd_ack0", bus.ack0, 1'b1);
        chk8("rd_data", bus.rdata, 8'hA5);
        step();
        bus.req0 = 1'b0;

        // Contention from reset release: 0,1,0,1
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 8'h40;
        bus.req1 = 1'b1; bus.addr1 = 8'h41; bus.write1 = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("ct_gnt0", bus.gnt0, (i % 2) == 0);
            chk1("ct_gnt1", bus.gnt1, (i % 2) == 1);
            chk1("ct_excl", bus.gnt0 & bus.gnt1, 1'b0);
            chk1("ct_noack", bus.ack0 | bus.ack1, 1'b0);
            step();
            chk1("ct_ack0", bus.ack0, (i % 2) == 0);
            chk1("ct_ack1", bus.ack1, (i % 2) == 1);
            step();
            chk1("ct_idle_ack", bus.ack0 | bus.ack1, 1'b0);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Lock with limit 4: 1,1,1,1,0,1
        do_reset();
        reset = 1'b1;
        bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.addr1 = 8'h50;
        bus.addr0 = 8'h60; bus.lock0 = 1'b0; bus.write0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) bus.req0 = 1'b1;
            chk1("lk_gnt1", bus.gnt1, exp_g[i]);
            chk1("lk_gnt0", bus.gnt0, ~exp_g[i]);
            step();
            chk1("lk_ack1", bus.ack1, exp_g[i]);
            chk1("lk_ack0", bus.ack0, ~exp_g[i]);
            step();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;

        // Lock release: locked read then unlocked write by master 0
        do_reset();
        reset = 1'b1;
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.write0 = 1'b0; bus.addr0 = 8'h20;
        step();
        chk1("lr_gnt0_a", bus.gnt0, 1'b1);
        bus.req1 = 1'b1; bus.write1 = 1'b0; bus.addr1 = 8'h20;
        step();
        chk1("lr_ack0_a", bus.ack0, 1'b1);
        step();
        bus.write0 = 1'b1; bus.wdata0 = 8'h21; bus.lock0 = 1'b0;
        step();
        chk1("lr_gnt0_b", bus.gnt0, 1'b1);
        chk1("lr_gnt1_b", bus.gnt1, 1'b0);
        chk1("lr_mwr_b", bus.mem_write, 1'b1);
        step();
        chk1("lr_ack0_b", bus.ack0, 1'b1);
        step();
        bus.req0 = 1'b0; bus.write0 = 1'b0;
        step();
        chk1("lr_gnt1_c", bus.gnt1, 1'b1);
        step();
        chk1("lr_ack1_c", bus.ack1, 1'b1);
        chk8("lr_rdata_c", bus.rdata, 8'h21);
        step();
        bus.req1 = 1'b0;

        // Reset during the ACCESS cycle of a write of 0x55 to 0x30
        bus.req0 = 1'b1; bus.write0 = 1'b1; bus.addr0 = 8'h30; bus.wdata0 = 8'h55;
        step();
        chk1("rw_mwr_access", bus.mem_write, 1'b1);
        reset = 1'b0;
        step();
        chk_all_zero("rw");
        reset = 1'b1;
        bus.write0 = 1'b0;
        bus.req1 = 1'b1; bus.write1 = 1'b0; bus.addr1 = 8'h31;
        step();
        chk1("rw_tie_gnt0", bus.gnt0, 1'b1);
        chk1("rw_tie_gnt1", bus.gnt1, 1'b0);
        chk8("rw_rd_addr", bus.mem_address, 8'h30);
        step();
        chk1("rw_rd_ack0", bus.ack0, 1'b1);
        chk8("rw_rd_data", bus.rdata, 8'h00);
        step();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
